bist_ora: RTL

- Output response analyzer (ORA) for the BIST loop; sits on the CUT output side, consuming the 2-bit `dataIn` response (`dataIn[0]` = sum, `dataIn[1]` = carry).
- Compresses NUM_PATTERNS responses into a MISR signature, compares it to a golden signature, and reports pass/fail.
- Counterpart to the pattern source that drives `a`/`b`/`cin`.

---
 rtl/bist_pkg.sv | 15 +
 rtl/misr_reg.sv | 42 ++++
 rtl/bist_ora.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST output response analyzer.
package bist_pkg;

    localparam int unsigned CutRespW = 2;
    localparam logic [7:0] DefPoly = 8'h1D;
    localparam logic [7:0] DefSeed = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCompare,
        StDone
    } ora_state_t;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: Galois-style shift with XOR of the parallel response.
module misr_reg
    import bist_pkg::*;
#(
    parameter int unsigned SIG_W = 8,
    parameter int unsigned DATA_W = CutRespW,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DefPoly),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(DefSeed)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_d, sig_q;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift_en) begin
            // The shift drops the MSB, which instead selects the feedback polynomial.
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-DATA_W){1'b0}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_ora.sv
// BIST output response analyzer: compresses CUT responses and compares against a golden signature.
// Optional watchdog abort is enabled by defining BIST_ORA_TIMEOUT_EN.
module bist_ora
    import bist_pkg::*;
#(
    parameter int unsigned DATA_W = CutRespW,
    parameter int unsigned SIG_W = 8,
    parameter int unsigned NUM_PATTERNS = 8,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DefPoly),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(DefSeed),
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(8'h47),
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned CntW = $clog2(NUM_PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] dataIn,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CntW-1:0]   pat_count,
    output logic              timeout
);

    ora_state_t      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    logic            pass_d, pass_q;
    logic            timeout_d, timeout_q;
    logic            misr_load;
    logic            misr_shift;
    logic [SIG_W-1:0] sig;

`ifdef BIST_ORA_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_d, wd_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    misr_reg #(
        .SIG_W    (SIG_W),
        .DATA_W   (DATA_W),
        .POLY     (POLY),
        .SEED     (SEED)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (misr_load),
        .shift_en (misr_shift),
        .din      (dataIn),
        .sig      (sig)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StCapture;
`ifdef BIST_ORA_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end
            end
            StCapture: begin
                if (data_valid) begin
                    misr_shift = 1'b1;
                    if (cnt_q < CntW'(NUM_PATTERNS)) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (cnt_q == CntW'(NUM_PATTERNS - 1)) begin
                        state_d = StCompare;
                    end
`ifdef BIST_ORA_TIMEOUT_EN
                    wd_d = '0;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    state_d   = StDone;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WdW'(1);
`endif
                end
            end
            StCompare: begin
                pass_d  = (sig == GOLDEN_SIG);
                state_d = StDone;
            end
        endcase

        // Status flags follow the next state so they line up with it after the edge.
        busy_d = (state_d == StCapture) || (state_d == StCompare);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
`ifdef BIST_ORA_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;
    assign pat_count = cnt_q;
    assign timeout   = timeout_q;

endmodule
